// File: rtl/imm_gen_pipe.sv
// Pipelined RV32/RV64 immediate generator: decodes the instruction immediate and
// delivers it through a registered valid/ready stage backed by a one-entry skid slot.
module imm_gen_pipe #(
    parameter int unsigned XLEN     = 32,
    parameter bit          ERR_ZERO = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [2:0]      in_fmt,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic            out_err
);

    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

    state_t            state, state_next;
    logic signed [31:0] dec32;
    logic [XLEN-1:0]   dec_imm;
    logic              dec_err;
    logic [XLEN-1:0]   skid_imm;
    logic              skid_err;
    logic              accept;
    logic              load_out_new, load_out_skid, load_skid;
    logic              s;
    logic              unused_opcode;

    assign s             = in_instr[31];
    assign accept        = in_valid & in_ready;
    assign unused_opcode = ^in_instr[6:0];

    // Every format is first formed as a 32-bit value whose bit 31 is the sign
    // (or zero for Z), so widening to XLEN is a single signed cast.
    always_comb begin
        dec32   = '0;
        dec_err = 1'b0;
        case (in_fmt)
            3'd0: dec32 = {{20{s}}, in_instr[31:20]};
            3'd1: dec32 = {{20{s}}, in_instr[31:25], in_instr[11:7]};
            3'd2: dec32 = {{19{s}}, in_instr[31], in_instr[7], in_instr[30:25],
                           in_instr[11:8], 1'b0};
            3'd3: dec32 = {in_instr[31:12], 12'b0};
            3'd4: dec32 = {{11{s}}, in_instr[31], in_instr[19:12], in_instr[20],
                           in_instr[30:21], 1'b0};
            3'd5: dec32 = {27'b0, in_instr[19:15]};
            default: begin
                dec_err = 1'b1;
                dec32   = ERR_ZERO ? '0 : {{20{s}}, in_instr[31:20]};
            end
        endcase
        dec_imm = XLEN'(dec32);
    end

    always_comb begin
        state_next    = state;
        load_out_new  = 1'b0;
        load_out_skid = 1'b0;
        load_skid     = 1'b0;
        case (state)
            EMPTY: begin
                if (accept) begin
                    load_out_new = 1'b1;
                    state_next   = ONE;
                end
            end
            ONE: begin
                if (accept && out_ready) begin
                    load_out_new = 1'b1;
                end else if (accept) begin
                    load_skid  = 1'b1;
                    state_next = FULL;
                end else if (out_ready) begin
                    state_next = EMPTY;
                end
            end
            FULL: begin
                if (out_ready) begin
                    load_out_skid = 1'b1;
                    state_next    = ONE;
                end
            end
            default: state_next = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
            in_ready  <= 1'b0;
        end else begin
            state     <= state_next;
            out_valid <= (state_next != EMPTY);
            in_ready  <= (state_next != FULL);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_imm  <= '0;
            out_err  <= 1'b0;
            skid_imm <= '0;
            skid_err <= 1'b0;
        end else begin
            if (load_out_new) begin
                out_imm <= dec_imm;
                out_err <= dec_err;
            end else if (load_out_skid) begin
                out_imm <= skid_imm;
                out_err <= skid_err;
            end
            if (load_skid) begin
                skid_imm <= dec_imm;
                skid_err <= dec_err;
            end
        end
    end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: three instances (RV32/ERR_ZERO=1, RV32/ERR_ZERO=0,
// RV64) share one stimulus stream; expected values are hand-computed constants.
module tb_imm_gen_pipe;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] in_instr;
    logic [2:0]  in_fmt;
    logic        out_ready;

    logic        rdy_a, vld_a, err_a;
    logic [31:0] imm_a;
    logic        rdy_b, vld_b, err_b;
    logic [31:0] imm_b;
    logic        rdy_c, vld_c, err_c;
    logic [63:0] imm_c;

    int n_tests = 0;
    int n_fail  = 0;

    imm_gen_pipe #(.XLEN(32), .ERR_ZERO(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_a),
        .in_instr(in_instr), .in_fmt(in_fmt), .out_valid(vld_a),
        .out_ready(out_ready), .out_imm(imm_a), .out_err(err_a)
    );

    imm_gen_pipe #(.XLEN(32), .ERR_ZERO(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_b),
        .in_instr(in_instr), .in_fmt(in_fmt), .out_valid(vld_b),
        .out_ready(out_ready), .out_imm(imm_b), .out_err(err_b)
    );

    imm_gen_pipe #(.XLEN(64), .ERR_ZERO(1'b1)) dut_c (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_c),
        .in_instr(in_instr), .in_fmt(in_fmt), .out_valid(vld_c),
        .out_ready(out_ready), .out_imm(imm_c), .out_err(err_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; outputs are sampled and inputs driven here.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] f, input logic [31:0] i);
        in_valid = v;
        in_fmt   = f;
        in_instr = i;
    endtask

    logic [2:0]  b2b_fmt   [5] = '{3'd1, 3'd3, 3'd2, 3'd4, 3'd5};
    logic [31:0] b2b_instr [5] = '{32'hFE20AE23, 32'h123450B7, 32'h80000063,
                                   32'h8000006F, 32'h000F8073};
    logic [31:0] b2b_exp   [5] = '{32'hFFFFFFFC, 32'h12345000, 32'hFFFFF000,
                                   32'hFFF00000, 32'h0000001F};

    initial begin
        rst_n     = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, 3'd0, 32'h0);

        step();
        step();
        check("rst_out_valid", 64'(vld_a), 64'd0);
        check("rst_out_imm",   64'(imm_a), 64'd0);
        check("rst_out_err",   64'(err_a), 64'd0);
        check("rst_in_ready",  64'(rdy_a), 64'd0);

        rst_n = 1'b1;
        step();
        check("post_rst_in_ready", 64'(rdy_a), 64'd1);

        // single I-type transfer, one-cycle latency
        drive(1'b1, 3'd0, 32'h80100093);
        step();
        check("i_valid", 64'(vld_a), 64'd1);
        check("i_imm",   64'(imm_a), 64'hFFFFF801);
        check("i_err",   64'(err_a), 64'd0);
        drive(1'b0, 3'd0, 32'h0);
        step();
        check("i_drain_valid", 64'(vld_a), 64'd0);

        // back-to-back, one result per cycle in order
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, b2b_fmt[k], b2b_instr[k]);
            check($sformatf("b2b%0d_in_ready", k), 64'(rdy_a), 64'd1);
            step();
            check($sformatf("b2b%0d_valid", k), 64'(vld_a), 64'd1);
            check($sformatf("b2b%0d_imm", k),   64'(imm_a), 64'(b2b_exp[k]));
        end
        drive(1'b0, 3'd0, 32'h0);
        step();
        check("b2b_drain_valid", 64'(vld_a), 64'd0);

        // backpressure: offer three pairs with out_ready low, only two fit
        out_ready = 1'b0;
        drive(1'b1, 3'd0, 32'h80100093);
        check("bp_acc1_ready", 64'(rdy_a), 64'd1);
        step();
        drive(1'b1, 3'd3, 32'h123450B7);
        check("bp_acc2_ready", 64'(rdy_a), 64'd1);
        check("bp_first_imm",  64'(imm_a), 64'hFFFFF801);
        step();
        check("bp_full_ready", 64'(rdy_a), 64'd0);
        check("bp_hold_imm1",  64'(imm_a), 64'hFFFFF801);
        drive(1'b1, 3'd1, 32'hFE20AE23);
        step();
        check("bp_third_ready", 64'(rdy_a), 64'd0);
        check("bp_hold_valid",  64'(vld_a), 64'd1);
        check("bp_hold_imm2",   64'(imm_a), 64'hFFFFF801);
        drive(1'b0, 3'd0, 32'h0);
        out_ready = 1'b1;
        step();
        check("bp_second_valid", 64'(vld_a), 64'd1);
        check("bp_second_imm",   64'(imm_a), 64'h12345000);
        check("bp_ready_back",   64'(rdy_a), 64'd1);
        step();
        check("bp_drain_valid", 64'(vld_a), 64'd0);

        // illegal formats and the 64-bit instance
        drive(1'b1, 3'd7, 32'h7FF00013);
        step();
        check("fmt7_imm_ez1", 64'(imm_a), 64'd0);
        check("fmt7_err_ez1", 64'(err_a), 64'd1);
        drive(1'b1, 3'd6, 32'h7FF00013);
        step();
        check("fmt6_imm_ez0", 64'(imm_b), 64'h000007FF);
        check("fmt6_err_ez0", 64'(err_b), 64'd1);
        check("fmt6_imm_ez1", 64'(imm_a), 64'd0);
        drive(1'b1, 3'd0, 32'h80100093);
        step();
        check("x64_i_imm", imm_c, 64'hFFFFFFFFFFFFF801);
        check("x64_i_err", 64'(err_c), 64'd0);
        drive(1'b1, 3'd3, 32'h800000B7);
        step();
        check("x64_u_imm", imm_c, 64'hFFFFFFFF80000000);
        check("x32_u_imm", 64'(imm_a), 64'h80000000);
        drive(1'b0, 3'd0, 32'h0);
        step();

        // reset while FULL discards both entries
        out_ready = 1'b0;
        drive(1'b1, 3'd0, 32'h80100093);
        step();
        drive(1'b1, 3'd4, 32'h8000006F);
        step();
        check("mid_full_ready", 64'(rdy_a), 64'd0);
        drive(1'b0, 3'd0, 32'h0);
        rst_n = 1'b0;
        step();
        check("mid_rst_valid", 64'(vld_a), 64'd0);
        check("mid_rst_imm",   64'(imm_a), 64'd0);
        check("mid_rst_ready", 64'(rdy_a), 64'd0);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        step();
        check("mid_post_ready", 64'(rdy_a), 64'd1);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("mid_no_stale%0d", k), 64'(vld_a), 64'd0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
